// File: rtl/skew_feeder_if.sv
// Operand bus between the operand SRAM side (master) and the skew feeder
// (slave), plus the staged lanes going out to the PE array edge.
//
// Handshake: a vector moves on a rising clock edge exactly when IN_VALID and
// IN_READY are both 1 in the cycle before that edge. IN_DATA must be stable
// while IN_VALID is 1. IN_READY never depends on IN_VALID. OUT_VALID is a
// per-lane qualifier with no back-pressure; the PE array always takes it.
interface skew_feeder_if #(
  parameter int NUM_LANES   = 32,
  parameter int OPND_BWIDTH = 8
);
  logic                             IN_VALID;
  logic                             IN_READY;
  logic [NUM_LANES*OPND_BWIDTH-1:0] IN_DATA;
  logic [NUM_LANES*OPND_BWIDTH-1:0] OUT_DATA;
  logic [NUM_LANES-1:0]             OUT_VALID;

  modport master (
    output IN_VALID, IN_DATA,
    input  IN_READY, OUT_DATA, OUT_VALID
  );

  modport slave (
    input  IN_VALID, IN_DATA,
    output IN_READY, OUT_DATA, OUT_VALID
  );
endinterface

// File: rtl/skew_feeder.sv
// Operand staging unit: accepts one NUM_LANES-wide vector per cycle and
// presents it to the PE array edge either diagonally skewed (lane i delayed
// i cycles) or aligned, then drains the skew tail and pulses DONE.
module skew_feeder #(
  parameter int NUM_LANES      = 32,
  parameter int NUM_LANES_LOG2 = 5,
  parameter int OPND_BWIDTH    = 8,
  parameter int MAX_LEN_LOG2   = 9
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    STALL,
  input  logic                    START,
  input  logic                    MODE_SKEW_in,
  input  logic [MAX_LEN_LOG2-1:0] LEN_in,
  skew_feeder_if.slave            bus,
  output logic                    BUSY_out,
  output logic                    DONE_out,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  // Drain runs NUM_LANES-1 cycles: counter values 0 .. NUM_LANES-2.
  localparam logic [NUM_LANES_LOG2-1:0] DRAIN_LAST = NUM_LANES_LOG2'(NUM_LANES - 2);
  localparam logic [NUM_LANES_LOG2-1:0] DRAIN_ONE  = NUM_LANES_LOG2'(1);
  localparam logic [MAX_LEN_LOG2-1:0]   LEN_ONE    = MAX_LEN_LOG2'(1);

  state_t                    state_q, state_d;
  logic [MAX_LEN_LOG2-1:0]   rem_q, rem_d;
  logic [NUM_LANES_LOG2-1:0] drain_q, drain_d;
  logic                      mode_q, mode_d;
  logic                      xfer;

  assign bus.IN_READY = (state_q == S_LOAD) & ~STALL;
  assign xfer         = bus.IN_VALID & bus.IN_READY;
  assign BUSY_out     = (state_q != S_IDLE);
  assign DONE_out     = (state_q == S_DONE);
  assign dbg_state    = state_q;

  // Control registers; STALL freezes the FSM and both counters.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      drain_q <= '0;
      mode_q  <= 1'b0;
    end else if (!STALL) begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drain_q <= drain_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and counter updates; mode and length are captured only at START.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          mode_d  = MODE_SKEW_in;
          rem_d   = LEN_in;
          drain_d = '0;
          state_d = (LEN_in == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          rem_d = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            drain_d = '0;
            state_d = mode_q ? S_DRAIN : S_DONE;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
        else                       drain_d = drain_q + DRAIN_ONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-lane shift chains: lane g has g+1 stages of {valid, data}. Stage 0 is
  // loaded on a transfer and otherwise gets a bubble. In aligned mode the
  // deeper stages are flushed with bubbles so a later skewed pass never sees
  // leftover vectors from an aligned pass.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [OPND_BWIDTH:0] chain [g+1];
    logic [OPND_BWIDTH:0] lane_out;

    // Advance the chain one stage per un-stalled cycle.
    always_ff @(posedge CLK) begin
      if (!RSTn) begin
        for (int k = 0; k <= g; k++) chain[k] <= '0;
      end else if (!STALL) begin
        chain[0] <= xfer ? {1'b1, bus.IN_DATA[g*OPND_BWIDTH +: OPND_BWIDTH]} : '0;
        for (int k = 1; k <= g; k++) chain[k] <= mode_q ? chain[k-1] : '0;
      end
    end

    // Bubbles carry zero data, so OUT_DATA is already 0 whenever valid is 0.
    assign lane_out = mode_q ? chain[g] : chain[0];
    assign bus.OUT_VALID[g] = lane_out[OPND_BWIDTH];
    assign bus.OUT_DATA[g*OPND_BWIDTH +: OPND_BWIDTH] = lane_out[OPND_BWIDTH-1:0];
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder with 4 lanes of 8 bits.
module tb_skew_feeder;
  localparam int NL = 4;
  localparam int BW = 8;
  localparam int LL = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          start;
  logic          mode_skew;
  logic [LL-1:0] len;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  skew_feeder_if #(.NUM_LANES(NL), .OPND_BWIDTH(BW)) bus ();

  skew_feeder #(
    .NUM_LANES(NL), .NUM_LANES_LOG2(2), .OPND_BWIDTH(BW), .MAX_LEN_LOG2(LL)
  ) dut (
    .CLK(clk), .RSTn(rst_n), .STALL(stall), .START(start),
    .MODE_SKEW_in(mode_skew), .LEN_in(len), .bus(bus),
    .BUSY_out(busy), .DONE_out(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lane i of vector v = 8'h10*v + i
  function automatic logic [NL*BW-1:0] vec(input int v);
    logic [NL*BW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*BW +: BW] = 8'(16 * v + i);
    return r;
  endfunction

  function automatic logic [BW-1:0] lane(input int i);
    return bus.OUT_DATA[i*BW +: BW];
  endfunction

  // driver: pulse START for one edge
  task automatic start_pass(input logic m, input logic [LL-1:0] l);
    start = 1'b1; mode_skew = m; len = l;
    tick();
    start = 1'b0; mode_skew = ~m; len = '1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int e = 0; e < 2; e++) begin
      stall = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      mode_skew = 1'($urandom_range(0, 1)); len = LL'($urandom_range(0, 511));
      bus.IN_VALID = 1'($urandom_range(0, 1)); bus.IN_DATA = $urandom;
      tick();
      n_checks++;
      if ({bus.IN_READY, bus.OUT_VALID, busy, done} !== '0 || bus.OUT_DATA !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs e%0d: rdy=%b ov=%b od=%h busy=%b done=%b required all 0",
                 e, bus.IN_READY, bus.OUT_VALID, bus.OUT_DATA, busy, done);
      end
    end
    rst_n = 1'b1; stall = 1'b0; start = 1'b0; bus.IN_VALID = 1'b0; bus.IN_DATA = '0;
    tick();
    start_pass(1'b1, 9'd2);
    n_checks++;
    if (busy !== 1'b1 || bus.IN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL start_response: busy=%b rdy=%b required 1 1", busy, bus.IN_READY);
    end
    bus.IN_VALID = 1'b1; bus.IN_DATA = vec(0);
    tick();
    bus.IN_VALID = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || bus.OUT_VALID !== '0 || bus.IN_READY !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midpass_reset: busy=%b ov=%b rdy=%b st=%0d required 0 0 0 0",
               busy, bus.OUT_VALID, bus.IN_READY, dbg_state);
    end
    tick();
  endtask

  // skew LEN=3, continuous vectors; cycle c is the cycle after transfer edge t0+c
  task automatic test_skew();
    start_pass(1'b1, 9'd3);
    for (int c = 0; c < 8; c++) begin
      bus.IN_VALID = (c < 3);
      bus.IN_DATA  = (c < 3) ? vec(c) : '0;
      if (c < 3) begin
        n_checks++;
        if (bus.IN_READY !== 1'b1) begin
          n_fail++;
          $display("FAIL skew_ready c%0d: got %b required 1", c, bus.IN_READY);
        end
      end
      tick();
      for (int i = 0; i < NL; i++) begin
        int v;
        logic ev;
        logic [BW-1:0] ed;
        v  = c - i;
        ev = (v >= 0 && v < 3);
        ed = ev ? 8'(16 * v + i) : 8'h00;
        n_checks++;
        if (bus.OUT_VALID[i] !== ev || lane(i) !== ed) begin
          n_fail++;
          $display("FAIL skew_lane%0d c%0d: got v=%b d=%h required v=%b d=%h",
                   i, c, bus.OUT_VALID[i], lane(i), ev, ed);
        end
      end
      n_checks++;
      if (done !== (c == 5)) begin
        n_fail++;
        $display("FAIL skew_done c%0d: got %b required %b", c, done, (c == 5));
      end
    end
    bus.IN_VALID = 1'b0;
  endtask

  // aligned LEN=2: vector v on all lanes in cycle c=v, DONE with the second
  task automatic test_aligned();
    start_pass(1'b0, 9'd2);
    for (int c = 0; c < 3; c++) begin
      bus.IN_VALID = (c < 2);
      bus.IN_DATA  = (c < 2) ? vec(c) : '0;
      tick();
      n_checks++;
      if (bus.OUT_VALID !== ((c < 2) ? 4'hf : 4'h0) || bus.OUT_DATA !== ((c < 2) ? vec(c) : '0)) begin
        n_fail++;
        $display("FAIL aligned_out c%0d: got v=%b d=%h", c, bus.OUT_VALID, bus.OUT_DATA);
      end
      n_checks++;
      if (done !== (c == 1) || busy !== (c < 2)) begin
        n_fail++;
        $display("FAIL aligned_ctrl c%0d: got done=%b busy=%b required %b %b",
                 c, done, busy, (c == 1), (c < 2));
      end
    end
    bus.IN_VALID = 1'b0;
  endtask

  // skew LEN=2 with one idle cycle between vectors
  task automatic test_bubble();
    start_pass(1'b1, 9'd2);
    for (int c = 0; c < 8; c++) begin
      bus.IN_VALID = (c == 0 || c == 2);
      bus.IN_DATA  = (c == 0) ? vec(0) : (c == 2) ? vec(1) : '0;
      if (c < 3) begin
        n_checks++;
        if (bus.IN_READY !== 1'b1) begin
          n_fail++;
          $display("FAIL bubble_ready c%0d: got %b required 1", c, bus.IN_READY);
        end
      end
      tick();
      for (int i = 0; i < NL; i++) begin
        int v;
        logic ev;
        logic [BW-1:0] ed;
        v  = c - i;
        ev = (v == 0 || v == 2);
        ed = (v == 0) ? 8'(i) : (v == 2) ? 8'(16 + i) : 8'h00;
        n_checks++;
        if (bus.OUT_VALID[i] !== ev || lane(i) !== ed) begin
          n_fail++;
          $display("FAIL bubble_lane%0d c%0d: got v=%b d=%h required v=%b d=%h",
                   i, c, bus.OUT_VALID[i], lane(i), ev, ed);
        end
      end
      n_checks++;
      if (done !== (c == 5)) begin
        n_fail++;
        $display("FAIL bubble_done c%0d: got %b required %b", c, done, (c == 5));
      end
    end
    bus.IN_VALID = 1'b0;
  endtask

  // skew LEN=1, stall for 2 edges in DRAIN with START pulsed during the stall
  task automatic test_stall();
    int e;
    start_pass(1'b1, 9'd1);
    e = 0;
    for (int c = 0; c < 7; c++) begin
      bus.IN_VALID = (c == 0);
      bus.IN_DATA  = (c == 0) ? vec(0) : '0;
      stall = (c == 1 || c == 2);
      start = stall; mode_skew = 1'b0; len = 9'd0;
      tick();
      if (!stall) e = c - ((c >= 3) ? 2 : 0);
      for (int i = 0; i < NL; i++) begin
        logic ev;
        logic [BW-1:0] ed;
        ev = (c < 6) && (e == i);
        ed = ev ? 8'(i) : 8'h00;
        n_checks++;
        if (bus.OUT_VALID[i] !== ev || lane(i) !== ed) begin
          n_fail++;
          $display("FAIL stall_lane%0d c%0d: got v=%b d=%h required v=%b d=%h",
                   i, c, bus.OUT_VALID[i], lane(i), ev, ed);
        end
      end
      n_checks++;
      if (done !== (c == 5) || busy !== (c < 6)) begin
        n_fail++;
        $display("FAIL stall_ctrl c%0d: got done=%b busy=%b required %b %b",
                 c, done, busy, (c == 5), (c < 6));
      end
    end
    bus.IN_VALID = 1'b0; start = 1'b0; stall = 1'b0;
    // START in IDLE while stalled must not start a pass
    stall = 1'b1; start = 1'b1; len = 9'd1; mode_skew = 1'b1;
    tick();
    stall = 1'b0; start = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle_start: busy=%b required 0", busy);
    end
  endtask

  // LEN=0: DONE the cycle after START, once; also DONE held under STALL
  task automatic test_len_zero();
    start_pass(1'b1, 9'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || bus.IN_READY !== 1'b0 || bus.OUT_VALID !== '0) begin
      n_fail++;
      $display("FAIL len0_done: done=%b busy=%b rdy=%b ov=%b required 1 1 0 0",
               done, busy, bus.IN_READY, bus.OUT_VALID);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.IN_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_after: done=%b busy=%b rdy=%b required 0 0 0", done, busy, bus.IN_READY);
    end
    start_pass(1'b0, 9'd0);
    stall = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold_stall: got %b required 1", done);
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_release: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  // back-to-back: aligned pass, then a skewed pass started right after DONE
  task automatic test_back_to_back();
    start_pass(1'b0, 9'd1);
    bus.IN_VALID = 1'b1; bus.IN_DATA = vec(5);
    tick();
    bus.IN_VALID = 1'b0; bus.IN_DATA = '0;
    tick();
    start_pass(1'b1, 9'd1);
    bus.IN_VALID = 1'b1; bus.IN_DATA = vec(6);
    for (int c = 0; c < 4; c++) begin
      tick();
      bus.IN_VALID = 1'b0; bus.IN_DATA = '0;
      n_checks++;
      if (bus.OUT_VALID !== 4'(1 << c) || lane(c) !== 8'(96 + c)) begin
        n_fail++;
        $display("FAIL b2b c%0d: got v=%b d=%h required v=%b d=%h",
                 c, bus.OUT_VALID, lane(c), 4'(1 << c), 8'(96 + c));
      end
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; start = 1'b0; mode_skew = 1'b0; len = '0;
    bus.IN_VALID = 1'b0; bus.IN_DATA = '0;
    test_reset();
    test_skew();
    test_aligned();
    test_bubble();
    test_stall();
    test_len_zero();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/skew_feeder.md
# skew_feeder

Parametrised operand staging unit between an operand SRAM and one edge of the PE array. It replaces the fixed per-lane FIFO bank with a single block. It accepts one NUM_LANES-wide operand vector per cycle over a valid/ready handshake and emits the vector either diagonally skewed (lane i delayed i cycles) or aligned (all lanes together). It also generates the zero-bubble drain tail and a completion pulse for the controller.

## Interface
- NUM_LANES, 32, lanes (PE rows or cols fed); ≥2
- NUM_LANES_LOG2, 5, log2(NUM_LANES)
- OPND_BWIDTH, 8, bits per lane element
- MAX_LEN_LOG2, 9, width of vector-count field
- CLK  in  1  clock; all state updates on rising edge
- RSTn  in  1  reset, synchronous, active-low
- STALL  in  1  freeze all state, counters and pipeline registers
- START  in  1  begin a pass; sampled only in IDLE with STALL=0
- MODE_SKEW_in  in  1  1 = skewed output, 0 = aligned; latched at START
- LEN_in  in  MAX_LEN_LOG2  vectors in this pass; latched at START
- IN_VALID  in  1  IN_DATA holds a vector
- IN_READY  out  1  block accepts a vector this cycle
- IN_DATA  in  NUM_LANES*OPND_BWIDTH  lane i at bits [(i+1)*OPND_BWIDTH-1 : i*OPND_BWIDTH]
- OUT_DATA  out  NUM_LANES*OPND_BWIDTH  staged lanes, same packing
- OUT_VALID  out  NUM_LANES  per-lane valid to the PE array
- BUSY_out  out  1  state ≠ IDLE
- DONE_out  out  1  pass-complete indication

## Operation
- FSM states are IDLE, LOAD, DRAIN, DONE.
- IDLE→LOAD on START when LEN_in≠0. IDLE→DONE on START when LEN_in=0.
- LOAD: IN_READY = (state==LOAD) & ~STALL. A transfer occurs when IN_VALID & IN_READY. The remaining-count register decrements on each transfer.
- On the transfer of the last vector: go to DRAIN if skewed, or to DONE if aligned.
- DRAIN: a counter runs NUM_LANES-1 un-stalled cycles, then the FSM goes to DONE.
- DONE lasts one un-stalled cycle, then returns to IDLE.
- Lane pipeline: lane i is a shift chain of (i+1) registers in skew mode, and 1 register in aligned mode. Each stage carries {valid, data}.
- A non-transfer cycle (IN_VALID=0, or not in LOAD) injects a bubble: valid=0, data=0.
- OUT_DATA for a lane is always 0 when its OUT_VALID bit is 0.
- STALL=1 holds every register, including the FSM and counters. IN_READY is 0 during STALL. START is ignored during STALL.
- START in any state other than IDLE is ignored.
- MODE_SKEW_in and LEN_in changes after START have no effect until the next pass.
- Counter widths: the remaining count uses MAX_LEN_LOG2 bits, and the drain counter uses NUM_LANES_LOG2 bits. No wrap is possible because the maximum LEN is 2^MAX_LEN_LOG2-1.
- Reset (RSTn=0 at an edge), including mid-pass: the FSM goes to IDLE, all pipeline stages are cleared, and the counters are cleared.

## Timing
- Reset values: IN_READY=0, OUT_DATA=0, OUT_VALID=0, BUSY_out=0, DONE_out=0.
- START sampled at edge s: BUSY_out=1 and IN_READY=1 (if not stalled) in the cycle after edge s.
- Vector accepted at edge t:
  - Skew mode: lane i shows it with OUT_VALID[i]=1 in the cycle after edge t+i.
  - Aligned mode: all lanes show it in the cycle after edge t.
- Last vector accepted at edge T: DONE_out=1 in the cycle after edge T+NUM_LANES-1 (skew) or after edge T (aligned). This is the same cycle in which OUT_VALID[NUM_LANES-1] shows the last vector.
- LEN=0: DONE_out=1 in the cycle after edge s, with no OUT_VALID asserted.
- DONE_out stays high while STALL holds the DONE state. It drops after the first un-stalled edge.
- Back-to-back passes: START may be accepted in the cycle after DONE. There is no pipeline overlap between passes.

## Test plan
- Reset: hold RSTn=0 for 2 edges with random inputs → all outputs 0, IN_READY=0. Then assert START, LEN=2 mid-LOAD, and reset again → IDLE, OUT_VALID=0 the next cycle.
- Skew, NUM_LANES=4, LEN=3, continuous IN_VALID, lane i of vector v = 8'h10*v+i:
  - Lane 3 shows 8'h03, 8'h13, 8'h23 in the 4th, 5th and 6th cycles after the first transfer edge.
  - DONE_out is high with 8'h23.
- Aligned, LEN=2: both vectors appear on all lanes 1 cycle after acceptance. DONE_out coincides with the second vector. There is no drain.
- Bubble: skew with LEN=2 and IN_VALID low for one cycle between vectors → every lane shows a one-cycle gap (valid=0, data=0) at its own skew offset. DONE_out is delayed by 1 cycle.
- Stall: skew with LEN=1 and STALL high for 2 cycles during DRAIN → OUT_DATA and OUT_VALID hold for those cycles, DONE_out arrives 2 cycles later, and START pulses during the stall are ignored.
- LEN=0: START → DONE_out=1 the next cycle, BUSY_out=1 for exactly that cycle, IN_READY never asserts.
